// File: rtl/three_operand_loader_if.sv
// Handshake bundle between the operand source, the loader and the
// three-operand adder stage. The loader sits on the slave modport; the
// master modport is the environment's view of it.
interface three_operand_loader_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic [WIDTH-1:0] a_input;
    logic [WIDTH-1:0] b_input;
    logic [WIDTH-1:0] c_input;
    logic             op_valid;
    logic             op_ready;

    modport master (
        output in_valid,
        output in_data,
        output op_ready,
        input  in_ready,
        input  a_input,
        input  b_input,
        input  c_input,
        input  op_valid
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  op_ready,
        output in_ready,
        output a_input,
        output b_input,
        output c_input,
        output op_valid
    );
endinterface

// File: rtl/three_operand_loader.sv
// Collects three consecutive upstream words into a_input/b_input/c_input and
// presents them as one triple to a downstream three-operand adder. A handoff
// and the first word of the next triple may share a cycle, so a continuous
// stream sustains one triple every three cycles.
module three_operand_loader #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    three_operand_loader_if.slave bus,
    output logic [7:0]            triple_count
);

    typedef enum logic [1:0] {LoadA, LoadB, LoadC, Hold} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] c_q;
    logic [7:0]       count_q;
    logic             accept;
    logic             handoff;

    // Handshake outputs depend only on registered state, clear and op_ready,
    // never on in_valid, so upstream cannot form a combinational loop.
    always_comb begin
        bus.op_valid = (state_q == Hold) && !clear;
        bus.in_ready = clear ? 1'b0 : ((state_q == Hold) ? bus.op_ready : 1'b1);
        accept       = bus.in_valid && bus.in_ready;
        handoff      = bus.op_valid && bus.op_ready;
        bus.a_input  = a_q;
        bus.b_input  = b_q;
        bus.c_input  = c_q;
        triple_count = count_q;
    end

    // Loader FSM: steps through the three operand slots, then holds the triple
    // until the adder takes it. clear aborts but keeps operand contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LoadA;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            count_q <= '0;
        end else if (clear) begin
            state_q <= LoadA;
        end else begin
            unique case (state_q)
                LoadA: begin
                    if (accept) begin
                        a_q     <= bus.in_data;
                        state_q <= LoadB;
                    end
                end
                LoadB: begin
                    if (accept) begin
                        b_q     <= bus.in_data;
                        state_q <= LoadC;
                    end
                end
                LoadC: begin
                    if (accept) begin
                        c_q     <= bus.in_data;
                        state_q <= Hold;
                    end
                end
                Hold: begin
                    if (handoff) begin
                        count_q <= count_q + 8'd1;
                        // A word accepted here starts the next triple directly.
                        if (accept) begin
                            a_q     <= bus.in_data;
                            state_q <= LoadB;
                        end else begin
                            state_q <= LoadA;
                        end
                    end
                end
                default: state_q <= LoadA;
            endcase
        end
    end

endmodule

// File: tb/tb_three_operand_loader.sv
// Bench for three_operand_loader: directed scenarios plus a randomized run,
// checked against a word-count model of the loader.
module tb_three_operand_loader;
    localparam int unsigned WIDTH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic [7:0] triple_count;

    three_operand_loader_if #(.WIDTH(WIDTH)) bus ();

    three_operand_loader #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .bus         (bus),
        .triple_count(triple_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: how many words of the current triple are held, their values,
    // and the number of triples handed off modulo 256.
    int               m_n;
    logic [WIDTH-1:0] m_ops[3];
    int               m_count;

    function automatic logic m_in_ready();
        if (clear) return 1'b0;
        if (m_n == 3) return bus.op_ready;
        return 1'b1;
    endfunction

    function automatic logic m_op_valid();
        return (m_n == 3) && !clear;
    endfunction

    task automatic model_reset();
        m_n     = 0;
        m_ops[0] = '0;
        m_ops[1] = '0;
        m_ops[2] = '0;
        m_count = 0;
    endtask

    task automatic set_in(input logic c, input logic v, input logic [WIDTH-1:0] d,
                          input logic r);
        clear        = c;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.op_ready = r;
        #1;
    endtask

    // Advance one clock and apply the same inputs to the model.
    task automatic tick();
        @(posedge clk);
        if (clear) begin
            m_n = 0;
        end else if (m_n < 3) begin
            if (bus.in_valid) begin
                m_ops[m_n] = bus.in_data;
                m_n++;
            end
        end else if (bus.op_ready) begin
            m_count = (m_count + 1) % 256;
            if (bus.in_valid) begin
                m_ops[0] = bus.in_data;
                m_n = 1;
            end else begin
                m_n = 0;
            end
        end
        #1;
    endtask

    task automatic feed(input logic [WIDTH-1:0] d, input logic r);
        set_in(1'b0, 1'b1, d, r);
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(1'b0, 1'b0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        checks += 5;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        if (bus.op_valid !== 1'b0) begin
            failures++; $display("FAIL reset_op_valid: got %b want 0", bus.op_valid);
        end
        if (triple_count !== 8'd0) begin
            failures++; $display("FAIL reset_count: got %0d want 0", triple_count);
        end
        if (bus.a_input !== '0 || bus.b_input !== '0) begin
            failures++; $display("FAIL reset_ab: got %h %h want 0 0", bus.a_input, bus.b_input);
        end
        if (bus.c_input !== '0) begin
            failures++; $display("FAIL reset_c: got %h want 0", bus.c_input);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        feed(16'h0001, 1'b1);
        feed(16'h0002, 1'b1);
        set_in(1'b0, 1'b1, 16'h0003, 1'b1);
        checks++;
        if (bus.op_valid !== 1'b0) begin
            failures++; $display("FAIL basic_early_valid: got %b want 0", bus.op_valid);
        end
        tick();
        set_in(1'b0, 1'b0, '0, 1'b1);
        checks += 2;
        if (bus.op_valid !== 1'b1) begin
            failures++; $display("FAIL basic_latency: got %b want 1", bus.op_valid);
        end
        if (bus.a_input !== 16'h0001 || bus.b_input !== 16'h0002 || bus.c_input !== 16'h0003) begin
            failures++;
            $display("FAIL basic_triple: got %h %h %h want 0001 0002 0003",
                     bus.a_input, bus.b_input, bus.c_input);
        end
        tick();
        checks += 2;
        if (triple_count !== 8'd1) begin
            failures++; $display("FAIL basic_count: got %0d want 1", triple_count);
        end
        if (bus.op_valid !== 1'b0) begin
            failures++; $display("FAIL basic_after: got %b want 0", bus.op_valid);
        end
    endtask

    task automatic test_hold_stall();
        feed(16'h1111, 1'b0);
        feed(16'h2222, 1'b0);
        feed(16'h3333, 1'b0);
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 1'b1, 16'h5555, 1'b0);
            checks += 2;
            if (bus.op_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hs[%0d]: got valid=%b ready=%b want 1 0",
                         i, bus.op_valid, bus.in_ready);
            end
            if (bus.a_input !== 16'h1111 || bus.b_input !== 16'h2222 || bus.c_input !== 16'h3333) begin
                failures++;
                $display("FAIL stall_ops[%0d]: got %h %h %h want 1111 2222 3333",
                         i, bus.a_input, bus.b_input, bus.c_input);
            end
            tick();
        end
        set_in(1'b0, 1'b1, 16'h4444, 1'b1);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL stall_release_ready: got %b want 1", bus.in_ready);
        end
        tick();
        set_in(1'b0, 1'b0, '0, 1'b0);
        checks += 2;
        if (bus.a_input !== 16'h4444 || bus.b_input !== 16'h2222) begin
            failures++;
            $display("FAIL stall_nobubble: got a=%h b=%h want 4444 2222", bus.a_input, bus.b_input);
        end
        if (bus.op_valid !== 1'b0) begin
            failures++; $display("FAIL stall_nobubble_valid: got %b want 0", bus.op_valid);
        end
        // Two more words must complete the triple if the loader is in LOAD_B.
        feed(16'h6666, 1'b1);
        feed(16'h7777, 1'b1);
        set_in(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (bus.op_valid !== 1'b1 || bus.a_input !== 16'h4444 || bus.c_input !== 16'h7777) begin
            failures++;
            $display("FAIL stall_next_triple: got v=%b a=%h c=%h want 1 4444 7777",
                     bus.op_valid, bus.a_input, bus.c_input);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] words[12];
        int start;
        int taken;
        start = m_count;
        taken = 0;
        for (int i = 0; i < 12; i++) words[i] = WIDTH'($urandom);
        for (int cyc = 0; cyc < 13; cyc++) begin
            if (cyc < 12) set_in(1'b0, 1'b1, words[cyc], 1'b1);
            else          set_in(1'b0, 1'b0, '0, 1'b1);
            checks++;
            if (bus.op_valid !== ((cyc % 3 == 0) && cyc > 0)) begin
                failures++;
                $display("FAIL b2b_valid[%0d]: got %b want %b",
                         cyc, bus.op_valid, (cyc % 3 == 0) && cyc > 0);
            end
            if (bus.op_valid === 1'b1 && taken < 4) begin
                checks++;
                if (bus.a_input !== words[3*taken] || bus.b_input !== words[3*taken+1] ||
                    bus.c_input !== words[3*taken+2]) begin
                    failures++;
                    $display("FAIL b2b_triple[%0d]: got %h %h %h want %h %h %h", taken,
                             bus.a_input, bus.b_input, bus.c_input,
                             words[3*taken], words[3*taken+1], words[3*taken+2]);
                end
                taken++;
            end
            tick();
        end
        checks++;
        if (triple_count !== 8'((start + 4) % 256)) begin
            failures++;
            $display("FAIL b2b_count: got %0d want %0d", triple_count, (start + 4) % 256);
        end
    endtask

    task automatic test_clear();
        int start;
        start = m_count;
        feed(16'hAAAA, 1'b1);
        feed(16'hBBBB, 1'b1);
        set_in(1'b1, 1'b1, 16'hCCCC, 1'b1);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.op_valid !== 1'b0) begin
            failures++;
            $display("FAIL clear_hs: got ready=%b valid=%b want 0 0", bus.in_ready, bus.op_valid);
        end
        tick();
        set_in(1'b0, 1'b0, '0, 1'b1);
        checks += 2;
        if (bus.a_input !== 16'hAAAA || bus.b_input !== 16'hBBBB) begin
            failures++;
            $display("FAIL clear_keep: got %h %h want aaaa bbbb", bus.a_input, bus.b_input);
        end
        if (bus.op_valid !== 1'b0) begin
            failures++; $display("FAIL clear_valid: got %b want 0", bus.op_valid);
        end
        feed(16'h0D01, 1'b1);
        feed(16'h0D02, 1'b1);
        feed(16'h0D03, 1'b1);
        set_in(1'b0, 1'b0, '0, 1'b1);
        checks += 2;
        if (bus.op_valid !== 1'b1 || bus.a_input !== 16'h0D01 || bus.b_input !== 16'h0D02 ||
            bus.c_input !== 16'h0D03) begin
            failures++;
            $display("FAIL clear_triple: got v=%b %h %h %h want 1 0d01 0d02 0d03",
                     bus.op_valid, bus.a_input, bus.b_input, bus.c_input);
        end
        if (triple_count !== 8'(start)) begin
            failures++; $display("FAIL clear_count: got %0d want %0d", triple_count, start);
        end
        tick();
    endtask

    task automatic test_async_reset();
        feed(16'h1234, 1'b0);
        feed(16'h5678, 1'b0);
        feed(16'h9ABC, 1'b0);
        set_in(1'b0, 1'b0, '0, 1'b0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks += 3;
        if (bus.a_input !== '0 || bus.b_input !== '0 || bus.c_input !== '0) begin
            failures++;
            $display("FAIL areset_ops: got %h %h %h want 0 0 0",
                     bus.a_input, bus.b_input, bus.c_input);
        end
        if (bus.op_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL areset_hs: got valid=%b ready=%b want 0 1", bus.op_valid, bus.in_ready);
        end
        if (triple_count !== 8'd0) begin
            failures++; $display("FAIL areset_count: got %0d want 0", triple_count);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        set_in(1'b0, 1'b1, 16'h7777, 1'b1);
        checks++;
        if (bus.op_valid !== 1'b0) begin
            failures++; $display("FAIL areset_stale: got %b want 0", bus.op_valid);
        end
        tick();
        feed(16'h8888, 1'b1);
        feed(16'h9999, 1'b1);
        set_in(1'b0, 1'b0, '0, 1'b1);
        checks++;
        if (bus.op_valid !== 1'b1 || bus.a_input !== 16'h7777 || bus.c_input !== 16'h9999) begin
            failures++;
            $display("FAIL areset_first: got v=%b a=%h c=%h want 1 7777 9999",
                     bus.op_valid, bus.a_input, bus.c_input);
        end
        tick();
    endtask

    task automatic test_wrap();
        int budget;
        budget = 0;
        while (m_count != 255 && budget < 1000) begin
            feed(WIDTH'($urandom), 1'b1);
            budget++;
        end
        set_in(1'b0, 1'b0, '0, 1'b0);
        checks++;
        if (budget >= 1000 || triple_count !== 8'd255) begin
            failures++; $display("FAIL wrap_255: got %0d want 255", triple_count);
        end
        budget = 0;
        while (m_count != 0 && budget < 10) begin
            feed(WIDTH'($urandom), 1'b1);
            budget++;
        end
        set_in(1'b0, 1'b0, '0, 1'b0);
        checks++;
        if (budget >= 10 || triple_count !== 8'd0) begin
            failures++; $display("FAIL wrap_0: got %0d want 0", triple_count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                   WIDTH'($urandom), ($urandom_range(0, 2) != 0));
            checks += 3;
            if (bus.in_ready !== m_in_ready() || bus.op_valid !== m_op_valid()) begin
                failures++;
                $display("FAIL rand_hs[%0d]: got ready=%b valid=%b want %b %b", i,
                         bus.in_ready, bus.op_valid, m_in_ready(), m_op_valid());
            end
            if (bus.a_input !== m_ops[0] || bus.b_input !== m_ops[1] ||
                bus.c_input !== m_ops[2]) begin
                failures++;
                $display("FAIL rand_ops[%0d]: got %h %h %h want %h %h %h", i, bus.a_input,
                         bus.b_input, bus.c_input, m_ops[0], m_ops[1], m_ops[2]);
            end
            if (triple_count !== 8'(m_count)) begin
                failures++;
                $display("FAIL rand_count[%0d]: got %0d want %0d", i, triple_count, m_count);
            end
            tick();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_hold_stall();
        test_back_to_back();
        test_clear();
        test_async_reset();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/three_operand_loader.md
THREE_OPERAND_LOADER -- requirements
Module: three_operand_loader

Interface
REQ-001 Parameter WIDTH, default 16, sets operand and input word width.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 clear  input  1  synchronous abort; discards any partial or held triple.
REQ-005 in_valid  input  1  upstream word valid.
REQ-006 in_data  input  WIDTH  upstream operand word.
REQ-007 in_ready  output  1  loader can accept in_data this cycle.
REQ-008 a_input  output  WIDTH  registered first operand of the triple.
REQ-009 b_input  output  WIDTH  registered second operand of the triple.
REQ-010 c_input  output  WIDTH  registered third operand of the triple.
REQ-011 op_valid  output  1  a_input, b_input and c_input form a complete triple.
REQ-012 op_ready  input  1  downstream three-operand adder stage consumes the triple.
REQ-013 triple_count  output  8  count of triples handed off (op_valid && op_ready).

Function
REQ-014 The FSM SHALL have four states: LOAD_A, LOAD_B, LOAD_C and HOLD.
REQ-015 An input word SHALL be accepted only in a cycle with in_valid && in_ready.
REQ-016 A triple handoff SHALL occur only in a cycle with op_valid && op_ready.
REQ-017 in_ready SHALL be: 1 in LOAD_A, LOAD_B and LOAD_C; op_ready in HOLD; 0 whenever clear=1.
REQ-018 op_valid SHALL be 1 only in HOLD with clear=0; it SHALL be a function of registered state and clear only, never of in_valid.
REQ-019 In LOAD_A, an accepted word SHALL load a_input, and the state SHALL go to LOAD_B.
REQ-020 In LOAD_B, an accepted word SHALL load b_input, and the state SHALL go to LOAD_C.
REQ-021 In LOAD_C, an accepted word SHALL load c_input, and the state SHALL go to HOLD.
REQ-022 With no accepted word, LOAD_A, LOAD_B and LOAD_C SHALL keep their state and all operand registers.
REQ-023 In HOLD with op_ready=0, the state and a_input, b_input and c_input SHALL stay stable, and no word SHALL be accepted.
REQ-024 HOLD with a handoff and no accepted word SHALL go to LOAD_A.
REQ-025 HOLD with a handoff and an accepted word in the same cycle SHALL load that word into a_input and go to LOAD_B, giving no bubble.
REQ-026 Latency: when the third word is accepted in cycle N, op_valid SHALL be 1 in cycle N+1.
REQ-027 Sustained throughput SHALL be one triple per three cycles when in_valid=1 and op_ready=1 continuously.
REQ-028 triple_count SHALL increment by 1 on each handoff and SHALL wrap from 255 to 0.
REQ-029 clear=1 SHALL force the next state to LOAD_A from any state.
REQ-030 clear=1 SHALL accept no word, perform no handoff, and leave triple_count unchanged.
REQ-031 clear SHALL NOT zero a_input, b_input or c_input.
REQ-032 Operand registers SHALL be loaded unmodified (no arithmetic); the downstream adder owns all summation and carry handling.
REQ-033 Words arriving while in_ready=0 SHALL NOT be lost: upstream holds them per valid/ready rules, and the loader SHALL NOT sample them.

Reset
REQ-034 reset=1 SHALL immediately, without waiting for clk, set: state to LOAD_A, a_input/b_input/c_input to 0, triple_count to 0, op_valid to 0 and in_ready to 1.
REQ-035 Reset asserted mid-triple or in HOLD SHALL discard the triple; after release, the first accepted word SHALL load a_input.
REQ-036 A triple completed before reset SHALL NOT be issued after reset release.

Verification
REQ-037 Scenario: in_valid=1 with words 0x0001, 0x0002, 0x0003 on consecutive cycles, op_ready=1 -> op_valid=1 one cycle after the third word with a_input=0x0001, b_input=0x0002, c_input=0x0003, then triple_count=1.
REQ-038 Scenario: triple 0x1111, 0x2222, 0x3333 loaded, op_ready held 0 for 5 cycles -> op_valid stays 1, outputs stable, in_ready=0; then op_ready=1 with in_valid=1 and in_data=0x4444 -> a_input=0x4444 and state LOAD_B on the next cycle.
REQ-039 Scenario: continuous stream of 12 words with op_ready=1 -> 4 triples issued in order and triple_count=4.
REQ-040 Scenario: clear pulsed after two words 0xAAAA, 0xBBBB -> state LOAD_A, no op_valid; the next three words form the triple.
REQ-041 Scenario: reset asserted asynchronously while in HOLD -> outputs immediately become 0 with op_valid=0 and in_ready=1, and triple_count=0.
REQ-042 Scenario: 256 triples issued -> triple_count wraps to 0.
